// File: rtl/execute_muldiv.sv
// rtl/execute_muldiv.sv - RV32IM execute stage: ALU, branch/jump resolution, iterative mul/div
//
// Sits between the ID/EX and EX/MEM registers; every output except ex_busy is a
// registered EX/MEM field.
//
// Ports:
//   clk, rst          clock, asynchronous active-low reset
//   keep              hold output registers and the mul/div engine
//   nop               load a bubble; aborts a running mul/div
//   in_valid          ID/EX slot holds a real instruction
//   pc, pcp4          instruction PC and PC+4
//   rs1_data/rs2_data forwarded operands; imm sign-extended immediate
//   alu_op, alu_src   ALU operation; [2:1] d1 sel 0/rs1/PC, [0] d2 sel imm/rs2
//   br_funct3         branch condition (BEQ..BGEU funct3)
//   is_branch/is_jal/is_jalr  control-transfer kind
//   is_muldiv, md_funct       M-extension op and its funct3
//   wreg, regwrite, memtoreg, memrw, membranch  control forwarded to MEM
//   ex_busy           combinational stall request to IF/ID
//   alu_result, br_target, br_taken, store_data, *_o  EX/MEM register
//
// Build option: EXE_FAST_MUL_EN - MUL/MULH/MULHSU/MULHU complete in one cycle
// like ALU ops; only DIV/DIVU/REM/REMU use the iterative engine.

module execute_muldiv #(
  parameter int XLEN    = 32,
  parameter int RADDR_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               keep,
  input  logic               nop,
  input  logic               in_valid,
  input  logic [XLEN-1:0]    pc,
  input  logic [XLEN-1:0]    pcp4,
  input  logic [XLEN-1:0]    rs1_data,
  input  logic [XLEN-1:0]    rs2_data,
  input  logic [XLEN-1:0]    imm,
  input  logic [3:0]         alu_op,
  input  logic [2:0]         alu_src,
  input  logic [2:0]         br_funct3,
  input  logic               is_branch,
  input  logic               is_jal,
  input  logic               is_jalr,
  input  logic               is_muldiv,
  input  logic [2:0]         md_funct,
  input  logic [RADDR_W-1:0] wreg,
  input  logic               regwrite,
  input  logic [1:0]         memtoreg,
  input  logic [1:0]         memrw,
  input  logic [2:0]         membranch,
  output logic               ex_busy,
  output logic [XLEN-1:0]    alu_result,
  output logic [XLEN-1:0]    br_target,
  output logic               br_taken,
  output logic [XLEN-1:0]    store_data,
  output logic [RADDR_W-1:0] wreg_o,
  output logic               regwrite_o,
  output logic [1:0]         memtoreg_o,
  output logic [1:0]         memrw_o,
  output logic [2:0]         membranch_o
);

  localparam int SHW  = $clog2(XLEN);
  localparam int CNTW = $clog2(XLEN);

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;
  localparam logic [3:0] ALU_PASS = 4'd10;

  localparam logic [2:0] MD_MUL    = 3'd0;
  localparam logic [2:0] MD_MULH   = 3'd1;
  localparam logic [2:0] MD_MULHSU = 3'd2;
  localparam logic [2:0] MD_MULHU  = 3'd3;
  localparam logic [2:0] MD_DIV    = 3'd4;
  localparam logic [2:0] MD_DIVU   = 3'd5;
  localparam logic [2:0] MD_REM    = 3'd6;
  localparam logic [2:0] MD_REMU   = 3'd7;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
  state_t state, state_nxt;

  // ---------------- ALU ----------------
  logic [XLEN-1:0] d1, d2, alu_out;
  logic [SHW-1:0]  shamt;

  always_comb begin
    case (alu_src[2:1])
      2'd1:    d1 = rs1_data;
      2'd2:    d1 = pc;
      default: d1 = '0;
    endcase
    d2    = alu_src[0] ? rs2_data : imm;
    shamt = d2[SHW-1:0];
    alu_out = '0;
    case (alu_op)
      ALU_ADD:  alu_out = d1 + d2;
      ALU_SUB:  alu_out = d1 - d2;
      ALU_SLL:  alu_out = d1 << shamt;
      ALU_SLT:  alu_out = {{(XLEN-1){1'b0}}, $signed(d1) < $signed(d2)};
      ALU_SLTU: alu_out = {{(XLEN-1){1'b0}}, d1 < d2};
      ALU_XOR:  alu_out = d1 ^ d2;
      ALU_SRL:  alu_out = d1 >> shamt;
      ALU_SRA:  alu_out = $signed(d1) >>> shamt;
      ALU_OR:   alu_out = d1 | d2;
      ALU_AND:  alu_out = d1 & d2;
      ALU_PASS: alu_out = d2;
      default:  alu_out = '0;
    endcase
  end

  // ---------------- branch / jump ----------------
  logic            br_cond;
  logic [XLEN-1:0] jalr_sum, target;

  always_comb begin
    case (br_funct3)
      3'b000:  br_cond = rs1_data == rs2_data;
      3'b001:  br_cond = rs1_data != rs2_data;
      3'b100:  br_cond = $signed(rs1_data) <  $signed(rs2_data);
      3'b101:  br_cond = $signed(rs1_data) >= $signed(rs2_data);
      3'b110:  br_cond = rs1_data <  rs2_data;
      3'b111:  br_cond = rs1_data >= rs2_data;
      default: br_cond = 1'b0;
    endcase
    jalr_sum = rs1_data + imm;
    target   = is_jalr ? {jalr_sum[XLEN-1:1], 1'b0} : pc + imm;
  end

  // ---------------- M-extension operand preparation ----------------
  // Signed ops work on magnitudes; the result sign is restored at the end.
  logic            a_signed, b_signed, a_neg, b_neg, md_iter, accept;
  logic [XLEN-1:0] a_mag, b_mag;

  always_comb begin
    a_signed = (md_funct == MD_MULH) || (md_funct == MD_MULHSU) ||
               (md_funct == MD_DIV)  || (md_funct == MD_REM);
    b_signed = (md_funct == MD_MULH) || (md_funct == MD_DIV) || (md_funct == MD_REM);
    a_neg    = a_signed & rs1_data[XLEN-1];
    b_neg    = b_signed & rs2_data[XLEN-1];
    a_mag    = a_neg ? -rs1_data : rs1_data;
    b_mag    = b_neg ? -rs2_data : rs2_data;
  end

`ifdef EXE_FAST_MUL_EN
  assign md_iter = is_muldiv & md_funct[2];

  // Sign-extended operands multiplied modulo 2^(2*XLEN) give the signed product.
  logic [2*XLEN-1:0] fast_prod;
  logic [XLEN-1:0]   fast_mul_res;
  always_comb begin
    fast_prod    = {{XLEN{a_neg}}, rs1_data} * {{XLEN{b_neg}}, rs2_data};
    fast_mul_res = (md_funct == MD_MUL) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
  end
`else
  assign md_iter = is_muldiv;
`endif

  assign accept  = (state == S_IDLE) & in_valid & md_iter & ~keep & ~nop;
  assign ex_busy = (state == S_RUN) | ((state == S_IDLE) & in_valid & md_iter);

  logic [XLEN-1:0] ex_result;
  always_comb begin
    ex_result = alu_out;
    if (is_jal || is_jalr) begin
      ex_result = pcp4;
    end
`ifdef EXE_FAST_MUL_EN
    else if (is_muldiv) begin
      ex_result = fast_mul_res;
    end
`endif
  end

  // ---------------- FSM ----------------
  logic [CNTW-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (!keep) begin
      case (state)
        S_IDLE: if (accept) state_nxt = S_RUN;
        S_RUN: begin
          if (nop)            state_nxt = S_IDLE;
          else if (cnt == 0)  state_nxt = S_DONE;
        end
        S_DONE:  state_nxt = S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // ---------------- iterative engine ----------------
  // Multiply: acc_lo holds the multiplier, opb the multiplicand; {acc_hi,acc_lo}
  // ends as the 2*XLEN product. Divide: acc_lo holds the dividend and collects
  // quotient bits, acc_hi is the partial remainder, opb the divisor.
  logic [XLEN-1:0]    acc_hi, acc_lo, opb, hi_nxt, lo_nxt, store_q;
  logic [2:0]         md_funct_q;
  logic               res_neg_q, rem_neg_q, div_zero_q, regwrite_q;
  logic [RADDR_W-1:0] wreg_q;
  logic [1:0]         memtoreg_q, memrw_q;
  logic [2:0]         membranch_q;
  logic [XLEN:0]      mul_sum, div_shift, div_diff;

  always_comb begin
    mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opb} : '0);
    div_shift = {acc_hi, acc_lo[XLEN-1]};
    div_diff  = div_shift - {1'b0, opb};
    if (md_funct_q[2]) begin
      if (!div_diff[XLEN]) begin
        hi_nxt = div_diff[XLEN-1:0];
        lo_nxt = {acc_lo[XLEN-2:0], 1'b1};
      end else begin
        hi_nxt = div_shift[XLEN-1:0];
        lo_nxt = {acc_lo[XLEN-2:0], 1'b0};
      end
    end else begin
      hi_nxt = mul_sum[XLEN:1];
      lo_nxt = {mul_sum[0], acc_lo[XLEN-1:1]};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt         <= '0;
      acc_hi      <= '0;
      acc_lo      <= '0;
      opb         <= '0;
      md_funct_q  <= '0;
      res_neg_q   <= 1'b0;
      rem_neg_q   <= 1'b0;
      div_zero_q  <= 1'b0;
      store_q     <= '0;
      wreg_q      <= '0;
      regwrite_q  <= 1'b0;
      memtoreg_q  <= '0;
      memrw_q     <= '0;
      membranch_q <= '0;
    end else if (accept) begin
      cnt         <= CNTW'(XLEN-1);
      acc_hi      <= '0;
      acc_lo      <= md_funct[2] ? a_mag : b_mag;
      opb         <= md_funct[2] ? b_mag : a_mag;
      md_funct_q  <= md_funct;
      res_neg_q   <= a_neg ^ b_neg;
      rem_neg_q   <= a_neg;
      div_zero_q  <= (rs2_data == '0);
      store_q     <= rs2_data;
      wreg_q      <= wreg;
      regwrite_q  <= regwrite;
      memtoreg_q  <= memtoreg;
      memrw_q     <= memrw;
      membranch_q <= membranch;
    end else if ((state == S_RUN) && !keep && !nop) begin
      acc_hi <= hi_nxt;
      acc_lo <= lo_nxt;
      if (cnt != '0) cnt <= cnt - 1'b1;
    end
  end

  // Final sign fix-up. MIN/-1 falls out naturally: |MIN| negated is MIN, remainder 0.
  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   md_result;

  always_comb begin
    prod_s = res_neg_q ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
    case (md_funct_q)
      MD_MUL:                       md_result = prod_s[XLEN-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU: md_result = prod_s[2*XLEN-1:XLEN];
      MD_DIV, MD_DIVU:              md_result = div_zero_q ? '1 : (res_neg_q ? -acc_lo : acc_lo);
      default:                      md_result = rem_neg_q ? -acc_hi : acc_hi;
    endcase
  end

  // ---------------- EX/MEM register ----------------
  // Defaults form the bubble; only DONE and a normal issue load real content.
  logic [XLEN-1:0]    alu_n, tgt_n, store_n;
  logic               taken_n, regwrite_n;
  logic [RADDR_W-1:0] wreg_n;
  logic [1:0]         memtoreg_n, memrw_n;
  logic [2:0]         membranch_n;

  always_comb begin
    alu_n       = '0;
    tgt_n       = '0;
    store_n     = '0;
    taken_n     = 1'b0;
    regwrite_n  = 1'b0;
    wreg_n      = '0;
    memtoreg_n  = '0;
    memrw_n     = '0;
    membranch_n = '0;
    if (nop) begin
      alu_n = '0;
    end else if (state == S_DONE) begin
      alu_n       = md_result;
      store_n     = store_q;
      regwrite_n  = regwrite_q;
      wreg_n      = wreg_q;
      memtoreg_n  = memtoreg_q;
      memrw_n     = memrw_q;
      membranch_n = membranch_q;
    end else if ((state == S_IDLE) && in_valid && !md_iter) begin
      alu_n       = ex_result;
      tgt_n       = target;
      taken_n     = is_jal | is_jalr | (is_branch & br_cond);
      store_n     = rs2_data;
      regwrite_n  = regwrite;
      wreg_n      = wreg;
      memtoreg_n  = memtoreg;
      memrw_n     = memrw;
      membranch_n = membranch;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      alu_result  <= '0;
      br_target   <= '0;
      br_taken    <= 1'b0;
      store_data  <= '0;
      wreg_o      <= '0;
      regwrite_o  <= 1'b0;
      memtoreg_o  <= '0;
      memrw_o     <= '0;
      membranch_o <= '0;
    end else if (!keep) begin
      alu_result  <= alu_n;
      br_target   <= tgt_n;
      br_taken    <= taken_n;
      store_data  <= store_n;
      wreg_o      <= wreg_n;
      regwrite_o  <= regwrite_n;
      memtoreg_o  <= memtoreg_n;
      memrw_o     <= memrw_n;
      membranch_o <= membranch_n;
    end
  end

endmodule

// File: tb/tb_execute_muldiv.sv
// tb/tb_execute_muldiv.sv - self-checking bench for execute_muldiv
module tb_execute_muldiv;

  localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_SLL = 4'd2, OP_SLT = 4'd3,
                         OP_SLTU = 4'd4, OP_XOR = 4'd5, OP_SRL = 4'd6, OP_SRA = 4'd7,
                         OP_OR = 4'd8, OP_AND = 4'd9, OP_PASS = 4'd10;

  logic        clk = 1'b0;
  logic        rst, keep, nop, in_valid;
  logic [31:0] pc, pcp4, rs1_data, rs2_data, imm;
  logic [3:0]  alu_op;
  logic [2:0]  alu_src, br_funct3, md_funct, membranch;
  logic        is_branch, is_jal, is_jalr, is_muldiv, regwrite;
  logic [4:0]  wreg;
  logic [1:0]  memtoreg, memrw;
  logic        ex_busy, br_taken, regwrite_o;
  logic [31:0] alu_result, br_target, store_data;
  logic [4:0]  wreg_o;
  logic [1:0]  memtoreg_o, memrw_o;
  logic [2:0]  membranch_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  execute_muldiv #(.XLEN(32), .RADDR_W(5)) dut (
    .clk(clk), .rst(rst), .keep(keep), .nop(nop), .in_valid(in_valid),
    .pc(pc), .pcp4(pcp4), .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm),
    .alu_op(alu_op), .alu_src(alu_src), .br_funct3(br_funct3),
    .is_branch(is_branch), .is_jal(is_jal), .is_jalr(is_jalr),
    .is_muldiv(is_muldiv), .md_funct(md_funct), .wreg(wreg),
    .regwrite(regwrite), .memtoreg(memtoreg), .memrw(memrw), .membranch(membranch),
    .ex_busy(ex_busy), .alu_result(alu_result), .br_target(br_target),
    .br_taken(br_taken), .store_data(store_data), .wreg_o(wreg_o),
    .regwrite_o(regwrite_o), .memtoreg_o(memtoreg_o), .memrw_o(memrw_o),
    .membranch_o(membranch_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    keep = 0; nop = 0; in_valid = 0; pc = 0; pcp4 = 4; rs1_data = 0; rs2_data = 0;
    imm = 0; alu_op = OP_ADD; alu_src = 3'b011; br_funct3 = 0; md_funct = 0;
    is_branch = 0; is_jal = 0; is_jalr = 0; is_muldiv = 0; regwrite = 0;
    wreg = 0; memtoreg = 0; memrw = 0; membranch = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: straight RISC-V semantics in plain arithmetic.
  function automatic logic [31:0] alu_model(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    int sa, sb, sh;
    sa = a; sb = b; sh = int'(b & 32'd31);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_SLL:  return a << sh;
      OP_SLT:  return (sa < sb) ? 32'd1 : 32'd0;
      OP_SLTU: return (a < b) ? 32'd1 : 32'd0;
      OP_XOR:  return a ^ b;
      OP_SRL:  return a >> sh;
      OP_SRA:  return 32'(sa >>> sh);
      OP_OR:   return a | b;
      OP_AND:  return a & b;
      OP_PASS: return b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic bit br_model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    sa = a; sb = b;
    case (f3)
      3'd0: return a == b;
      3'd1: return a != b;
      3'd4: return sa < sb;
      3'd5: return sa >= sb;
      3'd6: return a < b;
      3'd7: return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] md_model(input logic [2:0] f, input logic [31:0] a,
                                           input logic [31:0] b);
    int          ia, ib;
    longint      sa, sb, ub, p;
    logic [63:0] up;
    ia = a; ib = b; sa = ia; sb = ib; ub = longint'({32'd0, b});
    case (f)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin up = {32'd0, a} * {32'd0, b}; return up[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        p = sa / sb; return p[31:0];
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        p = sa % sb; return p[31:0];
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  task automatic run_alu(input string tag, input logic [3:0] op, input logic [2:0] src,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] im,
                         input logic [31:0] pcv);
    logic [31:0] d1, d2;
    logic [4:0]  wr;
    wr = 5'($urandom_range(31, 1));
    idle();
    in_valid = 1; alu_op = op; alu_src = src; rs1_data = a; rs2_data = b; imm = im;
    pc = pcv; pcp4 = pcv + 4; regwrite = 1; wreg = wr; memrw = 2'($urandom_range(3, 0));
    d1 = (src[2:1] == 2'd1) ? a : (src[2:1] == 2'd2) ? pcv : 32'd0;
    d2 = src[0] ? b : im;
    step();
    check({tag, " alu_result"}, alu_result, alu_model(op, d1, d2));
    check({tag, " store_data"}, store_data, b);
    check({tag, " wreg_o"}, 32'(wreg_o), 32'(wr));
    check({tag, " memrw_o"}, 32'(memrw_o), 32'(memrw));
    check({tag, " br_taken"}, 32'(br_taken), 32'd0);
  endtask

  task automatic run_br(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] pcv, input logic [31:0] im);
    idle();
    in_valid = 1; is_branch = 1; br_funct3 = f3; rs1_data = a; rs2_data = b;
    pc = pcv; pcp4 = pcv + 4; imm = im;
    step();
    check({tag, " br_taken"}, 32'(br_taken), 32'(br_model(f3, a, b)));
    check({tag, " br_target"}, br_target, pcv + im);
    check({tag, " regwrite_o"}, 32'(regwrite_o), 32'd0);
  endtask

  // Issues one M op, holds ID/EX while ex_busy, optionally stalls with keep.
  task automatic run_md(input string tag, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input int stall);
    int         busy, guard, kept;
    bit         leaked;
    logic [4:0] wr;
    wr = 5'($urandom_range(31, 1));
    idle();
    in_valid = 1; is_muldiv = 1; md_funct = f; rs1_data = a; rs2_data = b;
    wreg = wr; regwrite = 1;
    #1;
    check({tag, " busy_start"}, 32'(ex_busy), 32'd1);
    busy = 1; guard = 0; kept = 0; leaked = 0;
    while (ex_busy && guard < 200) begin
      keep = (busy >= 5) && (kept < stall);
      step();
      guard++;
      if (keep) kept++;
      if (ex_busy) busy++;
      if (regwrite_o) leaked = 1;
    end
    keep = 0;
    check({tag, " busy_cycles"}, 32'(busy), 32'(33 + stall));
    check({tag, " no_early_result"}, 32'(leaked), 32'd0);
    step();
    check({tag, " result"}, alu_result, md_model(f, a, b));
    check({tag, " regwrite_o"}, 32'(regwrite_o), 32'd1);
    check({tag, " wreg_o"}, 32'(wreg_o), 32'(wr));
    idle();
  endtask

  logic [31:0] ra, rb, ri, saved;
  logic [2:0]  f3s [6];
  bit          leak;

  initial begin
    f3s[0] = 3'd0; f3s[1] = 3'd1; f3s[2] = 3'd4; f3s[3] = 3'd5; f3s[4] = 3'd6; f3s[5] = 3'd7;
    idle();
    rst = 0;
    step();
    step();
    check("reset alu_result", alu_result, 32'd0);
    check("reset br_taken", 32'(br_taken), 32'd0);
    check("reset regwrite_o", 32'(regwrite_o), 32'd0);
    check("reset ex_busy", 32'(ex_busy), 32'd0);
    rst = 1;
    step();

    // Directed ALU / branch / jump cases
    run_alu("ADD", OP_ADD, 3'b011, 32'd5, 32'hFFFF_FFFD, 32'd0, 32'h40);
    check("ADD regwrite_o", 32'(regwrite_o), 32'd1);
    run_alu("SRA", OP_SRA, 3'b010, 32'h8000_0010, 32'd0, 32'd4, 32'h0);
    run_alu("AUIPC", OP_ADD, 3'b100, 32'd0, 32'd0, 32'h1000, 32'h300);
    run_br("BLT", 3'd4, 32'hFFFF_FFFF, 32'd1, 32'h100, 32'h20);
    run_br("BLTU", 3'd6, 32'hFFFF_FFFF, 32'd1, 32'h100, 32'h20);

    idle();
    in_valid = 1; is_jalr = 1; rs1_data = 32'h203; imm = 32'd2; pc = 32'h80; pcp4 = 32'h84;
    regwrite = 1; wreg = 5'd1;
    step();
    check("JALR br_target", br_target, 32'h204);
    check("JALR alu_result", alu_result, 32'h84);
    check("JALR br_taken", 32'(br_taken), 32'd1);

    // in_valid=0 loads a bubble even with live control bits
    idle();
    is_jal = 1; regwrite = 1; memrw = 2'd2;
    step();
    check("bubble regwrite_o", 32'(regwrite_o), 32'd0);
    check("bubble memrw_o", 32'(memrw_o), 32'd0);
    check("bubble br_taken", 32'(br_taken), 32'd0);

    // keep holds, nop bubbles
    run_alu("pre_keep", OP_ADD, 3'b011, 32'd100, 32'd23, 32'd0, 32'd0);
    saved = alu_result;
    in_valid = 1; alu_op = OP_SUB; rs1_data = 32'd1; rs2_data = 32'd9; keep = 1;
    step();
    check("keep alu_result", alu_result, saved);
    check("keep regwrite_o", 32'(regwrite_o), 32'd1);
    keep = 0;
    step();
    check("after_keep alu_result", alu_result, 32'hFFFF_FFF8);
    nop = 1;
    step();
    check("nop regwrite_o", 32'(regwrite_o), 32'd0);
    check("nop alu_result", alu_result, 32'd0);
    idle();

    // Directed M-extension corner cases
    run_md("MUL 7*-3", 3'd0, 32'd7, 32'hFFFF_FFFD, 0);
    check("MUL 7*-3 value", alu_result, 32'hFFFF_FFEB);
    run_md("DIV MIN/-1", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_md("REM MIN/-1", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_md("DIVU 9/0", 3'd5, 32'd9, 32'd0, 0);
    run_md("REMU 9/0", 3'd7, 32'd9, 32'd0, 0);
    run_md("DIV -7/0", 3'd4, 32'hFFFF_FFF9, 32'd0, 0);
    run_md("REM -7/2", 3'd6, 32'hFFFF_FFF9, 32'd2, 0);
    run_md("MULH stall", 3'd1, 32'h8000_0000, 32'h8000_0000, 4);
    run_md("MULHSU", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);

    // nop aborts a running divide
    idle();
    in_valid = 1; is_muldiv = 1; md_funct = 3'd4; rs1_data = 32'd1000; rs2_data = 32'd7;
    regwrite = 1; wreg = 5'd3;
    for (int i = 0; i < 10; i++) step();
    nop = 1;
    step();
    idle();
    #1;
    check("abort ex_busy", 32'(ex_busy), 32'd0);
    check("abort regwrite_o", 32'(regwrite_o), 32'd0);
    leak = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (regwrite_o || alu_result != 0) leak = 1;
    end
    check("abort no_result", 32'(leak), 32'd0);

    // asynchronous reset while running
    idle();
    in_valid = 1; is_muldiv = 1; md_funct = 3'd0; rs1_data = 32'd3; rs2_data = 32'd5;
    regwrite = 1; wreg = 5'd4;
    for (int i = 0; i < 5; i++) step();
    idle();
    rst = 0;
    #1;
    check("rst_run ex_busy", 32'(ex_busy), 32'd0);
    check("rst_run alu_result", alu_result, 32'd0);
    check("rst_run regwrite_o", 32'(regwrite_o), 32'd0);
    step();
    rst = 1;
    leak = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (regwrite_o || ex_busy) leak = 1;
    end
    check("rst_run no_result", 32'(leak), 32'd0);

    // async reset clears live outputs without a clock edge
    run_alu("pre_rst", OP_OR, 3'b011, 32'hF0, 32'h0F, 32'd0, 32'd0);
    #2;
    rst = 0;
    #1;
    check("async_rst alu_result", alu_result, 32'd0);
    check("async_rst regwrite_o", 32'(regwrite_o), 32'd0);
    step();
    rst = 1;
    step();

    // Randomized ALU, branch and M-extension traffic
    for (int i = 0; i < 60; i++) begin
      ra = $urandom; rb = ($urandom_range(3, 0) == 0) ? 32'($urandom_range(40, 0)) : $urandom;
      ri = $urandom;
      run_alu("rand_alu", 4'($urandom_range(10, 0)),
              {2'($urandom_range(2, 0)), 1'($urandom_range(1, 0))}, ra, rb, ri,
              {$urandom, 2'b00});
    end
    for (int i = 0; i < 30; i++) begin
      ra = $urandom;
      rb = ($urandom_range(2, 0) == 0) ? ra : $urandom;
      run_br("rand_br", f3s[$urandom_range(5, 0)], ra, rb, {$urandom, 2'b00},
             {{19{1'b0}}, 13'($urandom)});
    end
    for (int i = 0; i < 16; i++) begin
      ra = $urandom;
      rb = ($urandom_range(5, 0) == 0) ? 32'd0 :
           ($urandom_range(1, 0) == 0) ? 32'($urandom_range(300, 1)) : $urandom;
      run_md("rand_md", 3'($urandom_range(7, 0)), ra, rb, int'($urandom_range(2, 0)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
